// File: rtl/rec_pipe_pkg.sv
// Shared types and helpers for the recursive elastic pipeline rec_pipe.
package rec_pipe_pkg;

    localparam int MAX_DEPTH = 64;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_status_t;

    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rec_pipe_node.sv
// One register stage of rec_pipe; instantiates the rest of the chain below it.
// Optional flush input when REC_PIPE_FLUSH_EN is defined.
module rec_pipe_node
    import rec_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEVEL = 0,
    localparam int OCC_W = cnt_w(LEVEL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef REC_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [OCC_W-1:0] occ
);

    logic             v;
    logic [WIDTH-1:0] d;
    logic             fwd_ready;
    logic             flush_i;
    logic [OCC_W-1:0] tail_occ;
    stage_status_t    st;

`ifdef REC_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign st.valid = v;
    assign st.ready = !v || fwd_ready;
    assign up_ready = st.ready && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush_i) begin
            v <= 1'b0;
        end else if (up_valid && up_ready) begin
            v <= 1'b1;
            d <= up_data;
        end else if (st.valid && fwd_ready) begin
            v <= 1'b0;
        end
    end

    generate
        if (LEVEL == 0) begin : g_leaf
            assign fwd_ready = dn_ready;
            assign dn_valid  = v;
            assign dn_data   = d;
            assign tail_occ  = '0;
        end else begin : g_child
            localparam int CW = cnt_w(LEVEL);
            logic [CW-1:0] child_occ;

            rec_pipe_node #(
                .WIDTH (WIDTH),
                .LEVEL (LEVEL - 1)
            ) u_child (
                .clk      (clk),
                .rst_n    (rst_n),
`ifdef REC_PIPE_FLUSH_EN
                .flush    (flush),
`endif
                .up_valid (v),
                .up_ready (fwd_ready),
                .up_data  (d),
                .dn_valid (dn_valid),
                .dn_ready (dn_ready),
                .dn_data  (dn_data),
                .occ      (child_occ)
            );

            assign tail_occ = OCC_W'(child_occ);
        end
    endgenerate

    // Occupancy accumulates on the way back up the recursion.
    assign occ = tail_occ + OCC_W'(v);

endmodule

// File: rtl/rec_pipe.sv
// Elastic valid/ready pipeline of DEPTH stages built from recursive rec_pipe_node.
// Optional flush input when REC_PIPE_FLUSH_EN is defined.
module rec_pipe
    import rec_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef REC_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: the handshake passes straight through.
`ifdef REC_PIPE_FLUSH_EN
            assign in_ready  = out_ready && !flush;
            assign out_valid = in_valid && !flush;
`else
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
`endif
            assign out_data  = in_data;
            assign occupancy = '0;
        end else begin : g_chain
            rec_pipe_node #(
                .WIDTH (WIDTH),
                .LEVEL (DEPTH - 1)
            ) u_head (
                .clk      (clk),
                .rst_n    (rst_n),
`ifdef REC_PIPE_FLUSH_EN
                .flush    (flush),
`endif
                .up_valid (in_valid),
                .up_ready (in_ready),
                .up_data  (in_data),
                .dn_valid (out_valid),
                .dn_ready (out_ready),
                .dn_data  (out_data),
                .occ      (occupancy)
            );
        end
    endgenerate

endmodule

// File: tb/tb_rec_pipe.sv
// Self-checking bench for rec_pipe: conveyor model plus directed literal checks.
module tb_rec_pipe;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          fl        = 1'b0;
    wire           in_ready, out_valid;
    wire  [W-1:0]  out_data;
    wire  [CW-1:0] occupancy;

    logic       z_in_valid = 1'b0, z_out_ready = 1'b0;
    logic [0:0] z_in_data  = '0;
    wire        z_in_ready, z_out_valid;
    wire  [0:0] z_out_data, z_occ;

    rec_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef REC_PIPE_FLUSH_EN
        .flush     (fl),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    rec_pipe #(.WIDTH(1), .DEPTH(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef REC_PIPE_FLUSH_EN
        .flush     (fl),
`endif
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .in_data   (z_in_data),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .out_data  (z_out_data),
        .occupancy (z_occ)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: slots 1..D, beats move one slot per cycle toward the output if the slot ahead is free.
    bit         mv [1:D];
    logic [7:0] md [1:D];
    int         n_in  = 0;
    int         n_out = 0;

    function automatic int m_occ();
        int c = 0;
        for (int k = 1; k <= D; k++) c += int'(mv[k]);
        return c;
    endfunction

    function automatic bit m_accept(input bit ordy);
        bit tv [1:D];
        tv = mv;
        for (int k = D; k >= 1; k--) begin
            if (tv[k]) begin
                if (k == D) begin
                    if (ordy) tv[k] = 1'b0;
                end else if (!tv[k+1]) begin
                    tv[k+1] = 1'b1;
                    tv[k]   = 1'b0;
                end
            end
        end
        return !tv[1];
    endfunction

    task automatic m_step(input bit ordy, input bit ival, input logic [7:0] idata, input bit flsh);
        if (flsh) begin
            if (mv[D] && ordy) n_out++;
            n_in -= m_occ() - ((mv[D] && ordy) ? 1 : 0);
            for (int k = 1; k <= D; k++) mv[k] = 1'b0;
            return;
        end
        for (int k = D; k >= 1; k--) begin
            if (mv[k]) begin
                if (k == D) begin
                    if (ordy) begin
                        mv[k] = 1'b0;
                        n_out++;
                    end
                end else if (!mv[k+1]) begin
                    mv[k+1] = 1'b1;
                    md[k+1] = md[k];
                    mv[k]   = 1'b0;
                end
            end
        end
        if (ival && !mv[1]) begin
            mv[1] = 1'b1;
            md[1] = idata;
            n_in++;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            n_in -= m_occ();
            for (int k = 1; k <= D; k++) mv[k] = 1'b0;
        end else begin
            m_step(out_ready, in_valid, in_data, fl);
        end
    end

    // Compare process and emitted-beat monitor.
    logic [7:0] emitted [$];
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(fl ? 1'b0 : m_accept(out_ready)));
            chk("out_valid", 32'(out_valid), 32'(mv[D]));
            if (mv[D]) chk("out_data", 32'(out_data), 32'(md[D]));
            chk("occupancy", 32'(occupancy), 32'(m_occ()));
            if (out_valid && out_ready) emitted.push_back(out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] dat);
        bit r;
        in_valid = 1'b1;
        in_data  = dat;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // DEPTH=0 pass-through, all input combinations.
        for (int i = 0; i < 8; i++) begin
            z_in_valid  = i[2];
            z_in_data   = i[1];
            z_out_ready = i[0];
            #1;
            chk("d0_out_valid", 32'(z_out_valid), 32'(i[2]));
            chk("d0_out_data", 32'(z_out_data), 32'(i[1]));
            chk("d0_in_ready", 32'(z_in_ready), 32'(i[0]));
            chk("d0_occ", 32'(z_occ), 32'd0);
        end

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Back-to-back beats, no stall: 3-cycle latency.
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = 8'h11; cyc();
        in_data = 8'h22; cyc();
        in_data = 8'h33; cyc();
        in_valid = 1'b0;
        chk("lat_d0", 32'(out_data), 32'h11);
        chk("lat_occ_peak", 32'(occupancy), 32'd3);
        cyc();
        chk("lat_d1", 32'(out_data), 32'h22);
        chk("lat_occ2", 32'(occupancy), 32'd2);
        cyc();
        chk("lat_d2", 32'(out_data), 32'h33);
        cyc();
        chk("lat_empty", 32'(out_valid), 32'd0);

        // Backpressure: fill, hold stable, then drain in order.
        emitted.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'h40 + 8'(i));
        in_data = 8'h43;
        cyc(); cyc();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd3);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_data", 32'(out_data), 32'h40);
        cyc();
        chk("full_hold_data", 32'(out_data), 32'h40);
        out_ready = 1'b1;
        send_beat(8'h43);
        send_beat(8'h44);
        in_valid = 1'b0;
        repeat (6) cyc();
        chk("bp_count", 32'(emitted.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < emitted.size()) chk("bp_order", 32'(emitted[i]), 32'h40 + 32'(i));

        // Full throughput with simultaneous accept and emit.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'h60 + 8'(i));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(i);
            cyc();
            chk("thru_occ", 32'(occupancy), 32'd3);
        end
        in_valid = 1'b0;
        repeat (5) cyc();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("no_loss", 32'(n_out), 32'(n_in));

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 8'h99;
        cyc(); cyc(); cyc();
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = 8'hA5; cyc();
        in_valid = 1'b0;
        chk("post_rst_v0", 32'(out_valid), 32'd0);
        cyc();
        chk("post_rst_v1", 32'(out_valid), 32'd0);
        cyc();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'hA5);
        cyc();

`ifdef REC_PIPE_FLUSH_EN
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'h80 + 8'(i));
        in_data = 8'h77;
        fl = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        fl = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
